// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               path and the load/store path. Data wins arbitration unless
//               fetch has been starved for STARVE_MAX consecutive data grants.
//               One transaction is outstanding at a time; read data is steered
//               back to the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int             CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_CAP = CNT_W'(STARVE_MAX);
    localparam logic [2:0]     WAIT_LAST  = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic             owner_fetch;   // requester of the transaction in flight
    logic [CNT_W-1:0] starve;        // consecutive data grants while fetch waited
    logic [2:0]       wait_cnt;
    logic [31:0]      if_hold;       // last fetch word, held between rvalid pulses
    logic [31:0]      d_hold;        // last load word, held between rvalid pulses

    // Arbitration, transaction sequencing and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner_fetch <= 1'b0;
            starve      <= '0;
            wait_cnt    <= '0;
            if_hold     <= '0;
            d_hold      <= '0;
            if_gnt      <= 1'b0;
            d_gnt       <= 1'b0;
            if_rvalid   <= 1'b0;
            d_rvalid    <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= '0;
            mem_wdata   <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (if_req && (!d_req || starve == STARVE_CAP)) begin
                        owner_fetch <= 1'b1;
                        if_gnt      <= 1'b1;
                        mem_en      <= 1'b1;
                        mem_addr    <= if_addr;
                        starve      <= '0;
                        state       <= ISSUE;
                    end else if (d_req) begin
                        owner_fetch <= 1'b0;
                        d_gnt       <= 1'b1;
                        mem_en      <= 1'b1;
                        mem_addr    <= d_addr;
                        mem_we      <= d_we;
                        mem_wdata   <= d_wdata;
                        if (!if_req) begin
                            starve <= '0;
                        end else if (starve != STARVE_CAP) begin
                            starve <= starve + 1'b1;
                        end
                        state <= ISSUE;
                    end else begin
                        starve <= '0;
                    end
                end
                ISSUE: begin
                    // mem_we still shows the issued enables during this cycle
                    if (mem_we != 4'b0000) begin
                        state <= IDLE;
                    end else if (MEM_LAT == 1) begin
                        if_rvalid <= owner_fetch;
                        d_rvalid  <= !owner_fetch;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= 3'd1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if_rvalid <= owner_fetch;
                        d_rvalid  <= !owner_fetch;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (owner_fetch) begin
                        if_hold <= mem_rdata;
                    end else begin
                        d_hold <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Live memory data during the response cycle, held copy otherwise
    assign if_rdata = if_rvalid ? mem_rdata : if_hold;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_hold;
    assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter, one harness per memory
//               latency 1..4 running the same scenario in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        logic        fetch;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        fetch;
        logic [31:0] data;
        int          due;
    } rsp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    logic clk         = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lat
            localparam int L = gi + 1;

            logic        reset, if_req, if_gnt, if_rvalid, d_req, d_gnt, d_rvalid;
            logic        mem_en, busy;
            logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
            logic [31:0] mem_addr, mem_wdata, mem_rdata;
            logic [3:0]  d_we, mem_we;
            logic [31:0] pipe [L];
            req_t        exp_gnt [$];
            rsp_t        exp_rsp [$];
            req_t        d_stim [$];
            logic [31:0] f_stim [$];
            bit          fin = 1'b0;

            mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(4)) dut (
                .clk(clk), .reset(reset),
                .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
                .if_rvalid(if_rvalid), .if_rdata(if_rdata),
                .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
                .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
                .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
                .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
            );

            // Synchronous memory: read data valid L cycles after the mem_en cycle
            always @(posedge clk) begin
                pipe[0] <= (mem_en && mem_we == 4'b0000) ? mem_val(mem_addr) : (32'hBAD00000 | 32'(gi));
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
            assign mem_rdata = pipe[L-1];

            function automatic string t(input string s);
                return $sformatf("L%0d %s", L, s);
            endfunction

            // Monitor and request driver, both acting mid-cycle
            initial begin : mon_drv
                int          cyc = 0;
                bit          was_write = 1'b0;
                logic [31:0] last_if = '0;
                logic [31:0] last_d = '0;
                req_t        e;
                rsp_t        r;
                if_req = 1'b0; d_req = 1'b0;
                if_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (reset) begin
                        last_if = '0; last_d = '0; was_write = 1'b0;
                    end else begin
                        if (was_write) chk(t("busy_after_wr"), busy, 0);
                        was_write = 1'b0;
                        if (mem_en || if_gnt || d_gnt) begin
                            chk(t("mem_en"), mem_en, 1);
                            chk(t("one_gnt"), if_gnt ^ d_gnt, 1);
                            if (exp_gnt.size() == 0) begin
                                chk(t("unexp_gnt"), {if_gnt, d_gnt}, 0);
                            end else begin
                                e = exp_gnt.pop_front();
                                chk(t("gnt_is_fetch"), if_gnt, e.fetch);
                                chk(t("mem_addr"), mem_addr, e.addr);
                                chk(t("mem_we"), mem_we, e.we);
                                if (e.we != 4'b0000) begin
                                    chk(t("mem_wdata"), mem_wdata, e.wdata);
                                    was_write = 1'b1;
                                end else begin
                                    exp_rsp.push_back('{e.fetch, mem_val(e.addr), cyc + L});
                                end
                            end
                        end
                        if (if_rvalid || d_rvalid) begin
                            chk(t("rvalid_excl"), if_rvalid & d_rvalid, 0);
                            if (exp_rsp.size() == 0) begin
                                chk(t("unexp_rvalid"), {if_rvalid, d_rvalid}, 0);
                            end else begin
                                r = exp_rsp.pop_front();
                                chk(t("rvalid_cycle"), cyc, r.due);
                                chk(t("rvalid_is_fetch"), if_rvalid, r.fetch);
                                chk(t("rdata"), r.fetch ? if_rdata : d_rdata, r.data);
                            end
                        end
                        if (if_rvalid) last_if = if_rdata;
                        else chk(t("if_rdata_hold"), if_rdata, last_if);
                        if (d_rvalid) last_d = d_rdata;
                        else chk(t("d_rdata_hold"), d_rdata, last_d);
                    end
                    if (d_gnt && d_stim.size() > 0) void'(d_stim.pop_front());
                    if (if_gnt && f_stim.size() > 0) void'(f_stim.pop_front());
                    d_req = (d_stim.size() > 0);
                    if (d_req) begin
                        d_addr = d_stim[0].addr; d_we = d_stim[0].we; d_wdata = d_stim[0].wdata;
                    end
                    if_req = (f_stim.size() > 0);
                    if (if_req) if_addr = f_stim[0];
                end
            end

            task automatic stim_d(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
                d_stim.push_back('{1'b0, a, we, wd});
            endtask

            task automatic stim_f(input logic [31:0] a);
                f_stim.push_back(a);
            endtask

            task automatic expect_gnt(input req_t q);
                exp_gnt.push_back(q);
            endtask

            task automatic wait_idle();
                int n = 0;
                while ((exp_gnt.size() + exp_rsp.size() + d_stim.size() + f_stim.size()) != 0 && n < 400) begin
                    @(negedge clk); #1; n++;
                end
                chk(t("drain"), exp_gnt.size() + exp_rsp.size(), 0);
                exp_gnt.delete(); exp_rsp.delete(); d_stim.delete(); f_stim.delete();
                repeat (2) @(negedge clk);
                #1;
            endtask

            task automatic check_zero(input string s);
                chk(t({s, "_ctl"}), {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, busy, mem_we}, 0);
                chk(t({s, "_data"}), if_rdata | d_rdata | mem_addr | mem_wdata, 0);
            endtask

            // Scenario sequence
            initial begin : seq
                req_t        dl [12];
                logic [31:0] fa [2];
                int          n;
                reset = 1'b1;
                repeat (3) @(negedge clk);
                #1;
                check_zero("reset_state");
                reset = 1'b0;
                repeat (2) @(negedge clk);
                #1;

                // Single fetch
                stim_f(32'h40);
                expect_gnt('{1'b1, 32'h40, 4'h0, 32'h0});
                wait_idle();

                // Simultaneous requests: data first, then fetch
                stim_d(32'h100, 4'h0, 32'h0);
                stim_f(32'h44);
                expect_gnt('{1'b0, 32'h100, 4'h0, 32'h0});
                expect_gnt('{1'b1, 32'h44, 4'h0, 32'h0});
                wait_idle();

                // Partial store
                stim_d(32'h200, 4'b0011, 32'hDEADBEEF);
                expect_gnt('{1'b0, 32'h200, 4'b0011, 32'hDEADBEEF});
                wait_idle();

                // Starvation: D x4, F, D x4, F, then data resumes
                for (int i = 0; i < 12; i++) begin
                    dl[i] = '{1'b0, 32'h1000 + 32'(i * 4), (i % 3 == 2) ? 4'hF : 4'h0, 32'hA5000000 + 32'(i)};
                    stim_d(dl[i].addr, dl[i].we, dl[i].wdata);
                end
                fa[0] = 32'h80; fa[1] = 32'h84;
                stim_f(fa[0]); stim_f(fa[1]);
                for (int i = 0; i < 12; i++) begin
                    expect_gnt(dl[i]);
                    if (i == 3) expect_gnt('{1'b1, fa[0], 4'h0, 32'h0});
                    if (i == 7) expect_gnt('{1'b1, fa[1], 4'h0, 32'h0});
                end
                wait_idle();

                // Back-to-back fetch burst, then mixed data burst
                for (int i = 0; i < 5; i++) begin
                    fa[0] = $urandom & 32'hFFFFFFFC;
                    stim_f(fa[0]);
                    expect_gnt('{1'b1, fa[0], 4'h0, 32'h0});
                end
                wait_idle();
                for (int i = 0; i < 6; i++) begin
                    dl[0] = '{1'b0, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom};
                    stim_d(dl[0].addr, dl[0].we, dl[0].wdata);
                    expect_gnt(dl[0]);
                end
                wait_idle();

                // Reset in the middle of a read
                stim_d(32'h300, 4'h0, 32'h0);
                expect_gnt('{1'b0, 32'h300, 4'h0, 32'h0});
                n = 0;
                while (exp_gnt.size() != 0 && n < 50) begin
                    @(negedge clk); #1; n++;
                end
                chk(t("abort_gnt_seen"), exp_gnt.size(), 0);
                repeat ((L >= 2) ? 1 : 0) @(negedge clk);
                reset = 1'b1;
                #1;
                check_zero("abort_async");
                @(negedge clk); #1;
                check_zero("abort_edge");
                exp_gnt.delete(); exp_rsp.delete(); d_stim.delete(); f_stim.delete();
                reset = 1'b0;
                repeat (L + 3) @(negedge clk);
                #1;
                chk(t("abort_busy"), busy, 0);
                chk(t("abort_d_rdata"), d_rdata, 0);
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin : summary
        int n = 0;
        while (!(g_lat[0].fin && g_lat[1].fin && g_lat[2].fin && g_lat[3].fin) && n < 50000) begin
            @(negedge clk); n++;
        end
        chk("all_finished", {g_lat[0].fin, g_lat[1].fin, g_lat[2].fin, g_lat[3].fin}, 4'hF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
